// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one step per cycle on operand magnitudes.
module mul_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        load_hi,
  input  logic        load_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0]   acc_q;
  logic [W-1:0]     opnd_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;

  logic             signed_op;
  logic             is_div_op;
  logic [W-1:0]     mag_a;
  logic [W-1:0]     mag_b;
  logic [2*W-1:0]   acc_d;
  logic [W-1:0]     hi_d;
  logic [W-1:0]     lo_d;
  logic [W:0]       mul_sum;
  logic [W:0]       rem_sh;
  logic [W+1:0]     diff;
  logic [2*W-1:0]   prod;

  // Operand decode and magnitudes; op[0]=1 selects the unsigned variants.
  always_comb begin
    signed_op = ~op[0];
    is_div_op = op[1];
    mag_a     = (signed_op && a[W-1]) ? W'(-a) : a;
    mag_b     = (signed_op && b[W-1]) ? W'(-b) : b;
  end

  // One radix-2 step; acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : W'(0))};
    rem_sh  = acc_q[2*W-1:W-1];
    diff    = {1'b0, rem_sh} - {2'b00, opnd_q};
    acc_d   = {mul_sum, acc_q[W-1:1]};
    if (is_div_q) begin
      if (!diff[W+1]) acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
      else            acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

  // Sign correction of the final magnitudes.
  always_comb begin
    prod = neg_res_q ? (2*W)'(-acc_q) : acc_q;
    hi_d = prod[2*W-1:W];
    lo_d = prod[W-1:0];
    if (is_div_q) begin
      lo_d = neg_res_q ? W'(-acc_q[W-1:0])   : acc_q[W-1:0];
      hi_d = neg_rem_q ? W'(-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_div_op && (b == '0)) begin
              // Divide by zero completes immediately without iterating.
              hi_q    <= a;
              lo_q    <= '1;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              acc_q     <= {W'(0), mag_a};
              opnd_q    <= mag_b;
              is_div_q  <= is_div_op;
              neg_res_q <= signed_op && (a[W-1] ^ b[W-1]);
              neg_rem_q <= signed_op && a[W-1];
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= CALC;
            end
          end else begin
            if (load_hi) hi_q <= wdata;
            if (load_lo) lo_q <= wdata;
          end
        end
        CALC: begin
          if (cnt_q == LAST_STEP) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: results, latency, loads, ignored start and reset abort.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        load_hi, load_lo;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .load_hi(load_hi), .load_lo(load_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Edges after the start edge until done is seen, and busy cycles seen meanwhile.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input int elat);
    int lat, bc;
    issue(o, x, y);
    wait_done(lat, bc);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(elat));
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    @(negedge clock);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_dbz_clear"}, 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    int lat, bc, ndone;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wdata = '0; load_hi = 1'b0; load_lo = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    // MTHI then MTLO in IDLE
    load_hi = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clock);
    load_hi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hDEADBEEF);
    chk("mthi_lo", 64'(lo), 64'd0);
    load_lo = 1'b1; wdata = 32'h12345678;
    @(negedge clock);
    load_lo = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h12345678);
    chk("mtlo_hi", 64'(hi), 64'hDEADBEEF);

    run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    run("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
    run("div_neg_a", 2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    run("div_neg_b", 2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
    run("divu",      2'b11, 32'hDEADBEEF, 32'h10,       32'h0000000F, 32'h0DEADBEE, 1'b0, 33);
    run("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
    run("multu_big", 2'b01, 32'h80000000, 32'h00000003, 32'h00000001, 32'h80000000, 1'b0, 33);
    run("divu_zero", 2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 0);
    run("div_zero",  2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 0);

    // start and load_lo during CALC are ignored
    issue(2'b01, 32'd5, 32'd6);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 2'b11; b = 32'd0; load_lo = 1'b1; wdata = 32'h55;
    @(negedge clock);
    start = 1'b0; load_lo = 1'b0;
    chk("midcalc_lo_hold", 64'(lo), 64'hFFFFFFFF);
    chk("midcalc_busy", 64'(busy), 64'd1);
    chk("midcalc_dbz", 64'(div_by_zero), 64'd0);
    wait_done(lat, bc);
    chk("midcalc_lat", 64'(lat), 64'd27);
    chk("midcalc_hi", 64'(hi), 64'd0);
    chk("midcalc_lo", 64'(lo), 64'd30);
    ndone = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("midcalc_no_requeue", 64'(ndone), 64'd0);

    // start wins over loads at the same edge
    @(negedge clock);
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    load_hi = 1'b1; load_lo = 1'b1; wdata = 32'hAAAA;
    @(negedge clock);
    start = 1'b0; load_hi = 1'b0; load_lo = 1'b0;
    chk("prio_lo_kept", 64'(lo), 64'd30);
    chk("prio_busy", 64'(busy), 64'd1);
    wait_done(lat, bc);
    chk("prio_lat", 64'(lat), 64'd33);
    chk("prio_hi", 64'(hi), 64'd0);
    chk("prio_lo", 64'(lo), 64'd6);

    // reset aborts an operation at CALC step 10
    issue(2'b01, 32'hFFFFFFFF, 32'd7);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    run("after_abort", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
